// File: rtl/morse_key_sequencer.sv
// Turns manual Morse keying into dot/dash symbols, groups them into letter codes
// and stores each finished letter in a small circular buffer read by the display.
module morse_key_sequencer #(
    parameter int TICK_DIV   = 1_000_000,
    parameter int DASH_TICKS = 20,
    parameter int GAP_TICKS  = 60,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       button,
    input  logic                       send,
    input  logic                       clear,
    output logic [7:0]                 letter,
    output logic [1:0]                 dod,
    output logic                       commit,
    output logic [$clog2(DEPTH):0]     char_count,
    output logic                       full,
    output logic                       overflow,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [7:0]                 rd_data
);

    // state  | meaning
    // IDLE   | no key activity, waiting for a press
    // PRESS  | key held, timing the press in ticks
    // GAP    | key released, timing the inter-letter gap
    // COMMIT | single cycle: pending letter goes into the line buffer
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        GAP    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0] DASH_T = 8'(DASH_TICKS);
    localparam logic [7:0] GAP_T  = 8'(GAP_TICKS);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t state, state_next;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          btn_meta, btn_sync;
    logic [7:0]    press_cnt, gap_cnt;
    logic [2:0]    sym_count;
    logic          send_latched;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_idx;
    logic [7:0]    mem [DEPTH];

    logic clr_press, clr_gap, store_sym, drop_sym, do_commit, latch_send;
    logic send_pending;
    logic [1:0] sym_code;

    assign tick         = (tick_cnt == TICK_LAST);
    assign full         = (char_count == DEPTH_C);
    assign send_pending = send_latched | send;
    assign sym_code     = (press_cnt >= DASH_T) ? 2'b10 : 2'b01;
    assign dod          = (state == PRESS) ? sym_code : 2'b00;
    assign commit       = (state == COMMIT) && !full && !clear;
    assign rd_idx       = wr_ptr - char_count[AW-1:0] + rd_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= button;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_press  = 1'b0;
        clr_gap    = 1'b0;
        store_sym  = 1'b0;
        drop_sym   = 1'b0;
        do_commit  = 1'b0;
        latch_send = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_next = PRESS;
                    clr_press  = 1'b1;
                end else if (send && sym_count != 3'd0) begin
                    state_next = COMMIT;
                end
            end
            PRESS: begin
                latch_send = send;
                if (!btn_sync) begin
                    clr_gap = 1'b1;
                    if (press_cnt == 8'd0) begin
                        // Glitch: nothing to store, only resume what was pending.
                        if (sym_count == 3'd0)
                            state_next = IDLE;
                        else if (send_pending)
                            state_next = COMMIT;
                        else
                            state_next = GAP;
                    end else begin
                        if (sym_count < 3'd4)
                            store_sym = 1'b1;
                        else
                            drop_sym = 1'b1;
                        state_next = send_pending ? COMMIT : GAP;
                    end
                end
            end
            GAP: begin
                if (send || gap_cnt == GAP_T) begin
                    state_next = COMMIT;
                end else if (btn_sync) begin
                    state_next = PRESS;
                    clr_press  = 1'b1;
                end
            end
            COMMIT: begin
                do_commit  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            store_sym  = 1'b0;
            drop_sym   = 1'b0;
            do_commit  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_cnt    <= '0;
            gap_cnt      <= '0;
            send_latched <= 1'b0;
        end else begin
            if (clr_press)
                press_cnt <= '0;
            else if (state == PRESS && tick && press_cnt != 8'hFF)
                press_cnt <= press_cnt + 8'd1;

            if (clr_gap)
                gap_cnt <= '0;
            else if (state == GAP && tick && gap_cnt != 8'hFF)
                gap_cnt <= gap_cnt + 8'd1;

            if (clear || clr_press || do_commit)
                send_latched <= 1'b0;
            else if (latch_send)
                send_latched <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            letter     <= '0;
            sym_count  <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            char_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            letter     <= '0;
            sym_count  <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            char_count <= '0;
        end else begin
            if (store_sym) begin
                case (sym_count[1:0])
                    2'd0: letter[1:0] <= sym_code;
                    2'd1: letter[3:2] <= sym_code;
                    2'd2: letter[5:4] <= sym_code;
                    default: letter[7:6] <= sym_code;
                endcase
                sym_count <= sym_count + 3'd1;
            end
            if (drop_sym)
                overflow <= 1'b1;
            if (do_commit) begin
                // A full buffer drops the letter but the pending symbols still clear.
                if (!full) begin
                    mem[wr_ptr] <= letter;
                    wr_ptr      <= wr_ptr + 1'b1;
                    char_count  <= char_count + 1'b1;
                end
                letter    <= '0;
                sym_count <= '0;
                overflow  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (clear) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < char_count) begin
            rd_data <= mem[rd_idx];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with a fast tick (4 clocks per tick).
module tb_morse_key_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       button;
    logic       send;
    logic       clear;
    logic [7:0] letter;
    logic [1:0] dod;
    logic       commit;
    logic [2:0] char_count;
    logic       full;
    logic       overflow;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;
    int commit_cnt = 0;
    int c0;
    logic saw_dash;

    morse_key_sequencer #(
        .TICK_DIV(4), .DASH_TICKS(3), .GAP_TICKS(5), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .button(button), .send(send), .clear(clear),
        .letter(letter), .dod(dod), .commit(commit), .char_count(char_count),
        .full(full), .overflow(overflow), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (commit) commit_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holding 4n+2 clocks guarantees n or n+1 ticks regardless of tick phase.
    task automatic press(input int n);
        saw_dash = 1'b0;
        button = 1'b1;
        repeat (4 * n + 2) begin
            @(negedge clk);
            if (dod == 2'b10) saw_dash = 1'b1;
        end
        button = 1'b0;
    endtask

    task automatic pulse_send();
        send = 1'b1;
        cyc(1);
        send = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (letter !== 8'h00) begin failures++; $display("FAIL rst_letter got=%h exp=00", letter); end
        checks++; if (dod !== 2'b00) begin failures++; $display("FAIL rst_dod got=%b exp=00", dod); end
        checks++; if (commit !== 1'b0) begin failures++; $display("FAIL rst_commit got=%b exp=0", commit); end
        checks++; if (char_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", char_count); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
    endtask

    task automatic test_dot_gap_commit();
        c0 = commit_cnt;
        press(1);
        cyc(4);
        checks++; if (letter !== 8'h01) begin failures++; $display("FAIL t1_letter got=%h exp=01", letter); end
        cyc(30);
        checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL t1_commits got=%0d exp=1", commit_cnt - c0); end
        checks++; if (char_count !== 3'd1) begin failures++; $display("FAIL t1_count got=%0d exp=1", char_count); end
        rd_addr = 2'd0;
        cyc(2);
        checks++; if (rd_data !== 8'h01) begin failures++; $display("FAIL t1_rd0 got=%h exp=01", rd_data); end
    endtask

    task automatic test_dash_send();
        c0 = commit_cnt;
        press(4);
        checks++; if (saw_dash !== 1'b1) begin failures++; $display("FAIL t2_dod_dash got=%b exp=1", saw_dash); end
        cyc(8);
        press(1);
        cyc(4);
        checks++; if (letter !== 8'h06) begin failures++; $display("FAIL t2_letter got=%h exp=06", letter); end
        pulse_send();
        cyc(3);
        checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL t2_commits got=%0d exp=1", commit_cnt - c0); end
        checks++; if (letter !== 8'h00) begin failures++; $display("FAIL t2_letter_clr got=%h exp=00", letter); end
        checks++; if (char_count !== 3'd2) begin failures++; $display("FAIL t2_count got=%0d exp=2", char_count); end
        rd_addr = 2'd1;
        cyc(2);
        checks++; if (rd_data !== 8'h06) begin failures++; $display("FAIL t2_rd1 got=%h exp=06", rd_data); end
    endtask

    task automatic test_overflow();
        c0 = commit_cnt;
        for (int i = 0; i < 5; i++) begin
            press(1);
            if (i < 4) cyc(8);
        end
        cyc(4);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL t3_ovf got=%b exp=1", overflow); end
        checks++; if (letter !== 8'h55) begin failures++; $display("FAIL t3_letter got=%h exp=55", letter); end
        cyc(30);
        checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL t3_commits got=%0d exp=1", commit_cnt - c0); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL t3_ovf_clr got=%b exp=0", overflow); end
        rd_addr = 2'd2;
        cyc(2);
        checks++; if (rd_data !== 8'h55) begin failures++; $display("FAIL t3_rd2 got=%h exp=55", rd_data); end
    endtask

    task automatic test_full();
        logic [7:0] exp_codes [4];
        exp_codes[0] = 8'h01; exp_codes[1] = 8'h06; exp_codes[2] = 8'h55; exp_codes[3] = 8'h02;
        press(4);
        cyc(4);
        pulse_send();
        cyc(3);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL t4_full got=%b exp=1", full); end
        checks++; if (char_count !== 3'd4) begin failures++; $display("FAIL t4_count got=%0d exp=4", char_count); end
        c0 = commit_cnt;
        press(1);
        cyc(4);
        pulse_send();
        cyc(3);
        checks++; if (commit_cnt - c0 !== 0) begin failures++; $display("FAIL t4_drop_commits got=%0d exp=0", commit_cnt - c0); end
        checks++; if (char_count !== 3'd4) begin failures++; $display("FAIL t4_count_hold got=%0d exp=4", char_count); end
        checks++; if (letter !== 8'h00) begin failures++; $display("FAIL t4_letter_clr got=%h exp=00", letter); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            cyc(2);
            checks++;
            if (rd_data !== exp_codes[a]) begin
                failures++;
                $display("FAIL t4_rd%0d got=%h exp=%h", a, rd_data, exp_codes[a]);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        button = 1'b1;
        cyc(11);
        checks++; if (dod !== 2'b01) begin failures++; $display("FAIL t5_dod got=%b exp=01", dod); end
        reset = 1'b1;
        #1;
        checks++; if (dod !== 2'b00) begin failures++; $display("FAIL t5_dod_rst got=%b exp=00", dod); end
        checks++; if (char_count !== 3'd0) begin failures++; $display("FAIL t5_count_rst got=%0d exp=0", char_count); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL t5_full_rst got=%b exp=0", full); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL t5_rd_rst got=%h exp=00", rd_data); end
        button = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        press(1);
        cyc(4);
        checks++; if (letter !== 8'h01) begin failures++; $display("FAIL t5_letter got=%h exp=01", letter); end
        cyc(30);
        checks++; if (char_count !== 3'd1) begin failures++; $display("FAIL t5_count got=%0d exp=1", char_count); end
    endtask

    task automatic test_send_in_press_and_clear();
        c0 = commit_cnt;
        saw_dash = 1'b0;
        button = 1'b1;
        cyc(8);
        pulse_send();
        cyc(9);
        button = 1'b0;
        cyc(6);
        checks++; if (commit_cnt - c0 !== 1) begin failures++; $display("FAIL t6_commits got=%0d exp=1", commit_cnt - c0); end
        checks++; if (char_count !== 3'd2) begin failures++; $display("FAIL t6_count got=%0d exp=2", char_count); end
        rd_addr = 2'd1;
        cyc(2);
        checks++; if (rd_data !== 8'h02) begin failures++; $display("FAIL t6_rd1 got=%h exp=02", rd_data); end
        press(1);
        cyc(4);
        pulse_send();
        cyc(3);
        checks++; if (char_count !== 3'd3) begin failures++; $display("FAIL t6_count3 got=%0d exp=3", char_count); end
        rd_addr = 2'd0;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(2);
        checks++; if (char_count !== 3'd0) begin failures++; $display("FAIL t6_clr_count got=%0d exp=0", char_count); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL t6_clr_rd got=%h exp=00", rd_data); end
    endtask

    initial begin
        reset   = 1'b1;
        button  = 1'b0;
        send    = 1'b0;
        clear   = 1'b0;
        rd_addr = 2'd0;
        cyc(3);
        test_reset();
        reset = 1'b0;
        cyc(2);
        test_dot_gap_commit();
        test_dash_send();
        test_overflow();
        test_full();
        test_reset_mid_press();
        test_send_in_press_and_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
